// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port arbiter: default bus widths
// (also used by the RAM and CPU wrappers) and the read-response tag.
package bram_port_arbiter_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_ADDR_WIDTH = 16;

   // Identifies which requester owns the read data arriving on mem_q.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VID  = 2'd1,
      TAG_CPU  = 2'd2
   } resp_tag_t;

   // Tag for the access granted this cycle; writes produce no response.
   function automatic resp_tag_t next_tag(input logic vid_grant,
                                          input logic cpu_grant,
                                          input logic cpu_we);
      if (vid_grant)
         return TAG_VID;
      else if (cpu_grant && !cpu_we)
         return TAG_CPU;
      else
         return TAG_NONE;
   endfunction

endpackage

// File: rtl/bram_port_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles the CPU has been denied.
// at_max forces the CPU to win over VID on the next arbitration.
module bram_port_arbiter_starve_counter #(
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   logic [WAIT_W-1:0] wait_cnt;

   assign at_max = (wait_cnt == WAIT_W'(MAX_WAIT));

   // Count denied cycles, clear on grant or idle, saturate at MAX_WAIT.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (clr)
         wait_cnt <= '0;
      else if (inc && !at_max)
         wait_cnt <= wait_cnt + 1'b1;
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates one block-RAM port between the VID fetcher (read-only, high
// priority) and the CPU (read/write, low priority with starvation guard),
// and steers the registered read data back to the requester that asked.
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int MAX_WAIT   = 4,
   parameter int WAIT_W     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vid_req,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic                  vid_ack,
   output logic                  vid_rvalid,
   output logic [DATA_WIDTH-1:0] vid_rdata,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   logic                  cpu_grant;
   logic                  vid_grant;
   logic                  cpu_at_max;
   logic [ADDR_WIDTH-1:0] addr_q;
   resp_tag_t             tag_q;
   resp_tag_t             tag_d;

   // Starvation guard: counts cycles the CPU waits behind VID.
   bram_port_arbiter_starve_counter #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_starve (
      .clk    (clk),
      .reset  (reset),
      .inc    (cpu_req & ~cpu_grant),
      .clr    (~cpu_req | cpu_grant),
      .at_max (cpu_at_max)
   );

   // Grant: CPU when VID is idle or the CPU has waited MAX_WAIT cycles,
   // otherwise VID; nothing is granted while reset is held.
   // NOTE: every output of a combinational block gets a default first so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      cpu_grant = 1'b0;
      vid_grant = 1'b0;
      if (!reset) begin
         if (cpu_req && (!vid_req || cpu_at_max))
            cpu_grant = 1'b1;
         else if (vid_req)
            vid_grant = 1'b1;
      end
   end

   assign cpu_ack = cpu_grant;
   assign vid_ack = vid_grant;

   // RAM address follows the winner; with no winner it holds its last value.
   always_comb begin
      mem_addr = addr_q;
      if (cpu_grant)
         mem_addr = cpu_addr;
      else if (vid_grant)
         mem_addr = vid_addr;
   end

   assign mem_we   = cpu_grant & cpu_we;
   assign mem_data = reset ? '0 : cpu_wdata;

   // Remember the address driven this cycle for idle-cycle hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         addr_q <= '0;
      else
         addr_q <= mem_addr;
   end

   // Next response owner, aligned with the RAM's one-cycle read latency.
   always_comb begin
      tag_d = next_tag(vid_grant, cpu_grant, cpu_we);
   end

   // Response tag register; reset drops any read still in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tag_q <= TAG_NONE;
      else
         tag_q <= tag_d;
   end

   assign vid_rvalid = (tag_q == TAG_VID);
   assign cpu_rvalid = (tag_q == TAG_CPU);
   assign vid_rdata  = reset ? '0 : mem_q;
   assign cpu_rdata  = reset ? '0 : mem_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a write-first RAM model closes the loop,
// the driver predicts grants from the priority/starvation rules and
// queues expected read data, and a monitor compares every response.
module tb_bram_port_arbiter;
   import bram_port_arbiter_pkg::*;

   localparam int DW       = 16;
   localparam int AW       = 16;
   localparam int MAX_WAIT = 4;
   localparam int WAIT_W   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          vid_req, vid_ack, vid_rvalid;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_rdata;
   logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data, mem_q;
   logic          mem_we;

   int errors = 0;
   int checks = 0;

   // Reference state: memory contents, CPU denial run, last driven address.
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   int            denied = 0;
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] vid_q[$];
   logic [DW-1:0] cpu_q[$];

   always #5 clk = ~clk;

   bram_port_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MAX_WAIT   (MAX_WAIT),
      .WAIT_W     (WAIT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_ack    (vid_ack),
      .vid_rvalid (vid_rvalid),
      .vid_rdata  (vid_rdata),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_we     (mem_we),
      .mem_q      (mem_q)
   );

   // Block RAM port: registered read, write-first.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_we)
         ram[mem_addr] <= mem_data;
      mem_q <= mem_we ? mem_data : ram[mem_addr];
   end

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One arbitration cycle, called at a falling edge; returns at the next one.
   task automatic drive_cycle(input logic vr, input logic [AW-1:0] va,
                              input logic cr, input logic cw,
                              input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              output logic vg, output logic cg);
      logic ec, ev;
      vid_req = vr; vid_addr = va;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      #1;
      ec = cr && (!vr || denied == MAX_WAIT);
      ev = vr && !ec;
      check("vid_ack", vid_ack, ev);
      check("cpu_ack", cpu_ack, ec);
      check("mem_we", mem_we, ec && cw);
      if (ec || ev)
         check("mem_addr", mem_addr, ec ? ca : va);
      else
         check("mem_addr_hold", mem_addr, last_addr);
      if (ec && cw)
         check("mem_data", mem_data, cd);
      if (ev) begin
         vid_q.push_back(shadow[va]);
         last_addr = va;
      end
      if (ec) begin
         last_addr = ca;
         if (cw) shadow[ca] = cd;
         else    cpu_q.push_back(shadow[ca]);
      end
      if (cr && !ec) denied = (denied < MAX_WAIT) ? denied + 1 : denied;
      else           denied = 0;
      vg = ev;
      cg = ec;
      @(negedge clk);
   endtask

   task automatic idle();
      logic vg, cg;
      drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, vg, cg);
   endtask

   task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
      logic vg, cg;
      cg = 1'b0;
      for (int i = 0; i < 16 && !cg; i++)
         drive_cycle(1'b0, '0, 1'b1, we, a, d, vg, cg);
      if (!cg) check("cpu_grant_timeout", 0, 1);
   endtask

   task automatic vid_read(input logic [AW-1:0] a);
      logic vg, cg;
      vg = 1'b0;
      for (int i = 0; i < 16 && !vg; i++)
         drive_cycle(1'b1, a, 1'b0, 1'b0, '0, '0, vg, cg);
      if (!vg) check("vid_grant_timeout", 0, 1);
   endtask

   // Response monitor: each queued read must appear exactly one cycle later.
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (vid_rvalid) begin
            if (vid_q.size() == 0) check("vid_rvalid_unexpected", 1, 0);
            else                   check("vid_rdata", vid_rdata, vid_q.pop_front());
         end else if (vid_q.size() != 0) begin
            check("vid_rvalid_missing", 0, 1);
            void'(vid_q.pop_front());
         end
         if (cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
            else                   check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
         end else if (cpu_q.size() != 0) begin
            check("cpu_rvalid_missing", 0, 1);
            void'(cpu_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic          vg, cg, vr, cr, cw;
      logic [AW-1:0] va, ca;
      logic [DW-1:0] cd;
      int            t_ack;

      reset = 1'b1;
      vid_req = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_outputs",
            {vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
             mem_addr, mem_data, mem_we}, '0);
      @(negedge clk);
      reset = 1'b0;

      // Single VID read of a preloaded word.
      cpu_access(1'b1, 16'h0010, 16'hBEEF);
      idle();
      vid_read(16'h0010);
      idle();

      // CPU write then read-back on the following cycle.
      cpu_access(1'b1, 16'h00C8, 16'h1234);
      cpu_access(1'b0, 16'h00C8, '0);
      idle();

      // Pipelined VID reads on consecutive cycles.
      for (int i = 0; i < 3; i++)
         cpu_access(1'b1, 16'h0100 + 16'(i), 16'h00A0 + 16'(i));
      for (int i = 0; i < 3; i++)
         vid_read(16'h0100 + 16'(i));
      idle();

      // Alternating response tags.
      cpu_access(1'b1, 16'h0001, 16'h0011);
      cpu_access(1'b1, 16'h0002, 16'h0022);
      vid_read(16'h0001);
      cpu_access(1'b0, 16'h0002, '0);
      idle();
      idle();

      // Contention: VID streams, CPU must win after MAX_WAIT denials.
      cr = 1'b1;
      t_ack = -1;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, 16'h0100 + 16'(i % 3), cr, 1'b0, 16'h00C8, '0, vg, cg);
         if (cg) begin
            if (t_ack < 0) t_ack = i;
            cr = 1'b0;
         end
      end
      check("starve_bound", t_ack, MAX_WAIT);
      idle();

      // Randomized traffic over a small, preloaded window.
      for (int i = 0; i < 16; i++)
         cpu_access(1'b1, 16'h0100 + 16'(i), 16'($urandom));
      vr = 1'b0; cr = 1'b0; cw = 1'b0;
      va = '0; ca = '0; cd = '0;
      for (int i = 0; i < 600; i++) begin
         if (!vr && $urandom_range(0, 99) < 75) begin
            vr = 1'b1;
            va = 16'h0100 + 16'($urandom_range(0, 15));
         end
         if (!cr && $urandom_range(0, 99) < 50) begin
            cr = 1'b1;
            cw = 1'($urandom_range(0, 1));
            ca = 16'h0100 + 16'($urandom_range(0, 15));
            cd = 16'($urandom);
         end
         drive_cycle(vr, va, cr, cw, ca, cd, vg, cg);
         if (vg) vr = 1'b0;
         if (cg) cr = 1'b0;
      end
      idle();
      idle();

      // Reset asserted between a VID ack and its response edge.
      vid_req = 1'b1; vid_addr = 16'h0010;
      cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      check("rst_pre_ack", vid_ack, 1);
      #1;
      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 16'hA5A5;
      #1;
      check("rst_outputs_async",
            {vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
             mem_addr, mem_data, mem_we}, '0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_mem_we", mem_we, 0);
         check("rst_outputs_held",
               {vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
                mem_addr, mem_data, mem_we}, '0);
      end
      @(negedge clk);
      vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      vid_q.delete();
      cpu_q.delete();
      denied = 0;
      last_addr = '0;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle();
         check("rst_no_vid_rvalid", vid_rvalid, 0);
         check("rst_no_cpu_rvalid", cpu_rvalid, 0);
      end

      // CPU wins immediately after reset while VID streams: counter restarted.
      cr = 1'b1;
      t_ack = -1;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 16'h0101, cr, 1'b0, 16'h0102, '0, vg, cg);
         if (cg) begin
            if (t_ack < 0) t_ack = i;
            cr = 1'b0;
         end
      end
      check("starve_bound_after_reset", t_ack, MAX_WAIT);
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM between two requesters: the video/sprite fetcher (VID, read-only, high priority) and the CPU data interface (CPU, read/write, low priority).
- Grants at most one access per cycle and drives the RAM port.
- Routes the RAM's 1-cycle registered read data back to the requester that issued the read.
- A starvation counter guarantees CPU progress while VID streams continuously.

Parameters:
- DATA_WIDTH, 16: RAM word width.
- ADDR_WIDTH, 16: RAM address width.
- MAX_WAIT, 4: consecutive cycles the CPU may be denied before it is forced to win. Must be ≥1.
- WAIT_W, 3: counter width. Must satisfy 2**WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  VID read request; held until acked.
- vid_addr  in  ADDR_WIDTH  VID read address.
- vid_ack  out  1  VID request accepted this cycle (combinational).
- vid_rvalid  out  1  vid_rdata valid (registered).
- vid_rdata  out  DATA_WIDTH  read data for VID.
- cpu_req  in  1  CPU request; held until acked.
- cpu_we  in  1  CPU write enable (1 = write, 0 = read).
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid (registered); never asserted for writes.
- cpu_rdata  out  DATA_WIDTH  read data for CPU.
- mem_addr  out  ADDR_WIDTH  to RAM port address.
- mem_data  out  DATA_WIDTH  to RAM port write data.
- mem_we  out  1  to RAM port write enable.
- mem_q  in  DATA_WIDTH  RAM port read data, registered one cycle after the address.

Behaviour:
- Reset values and reset gating:
  - While reset is high: all outputs are 0, including mem_addr and mem_data; wait_cnt = 0; resp_tag = NONE.
  - Acks and mem_we are gated low while reset is high.
- Grant rule, evaluated combinationally each cycle:
  - If cpu_req and (not vid_req or wait_cnt == MAX_WAIT) -> grant CPU.
  - Otherwise, if vid_req -> grant VID.
  - Otherwise -> no grant.
- Ack: exactly one of vid_ack/cpu_ack is high when a grant is made, and it equals the grant.
- RAM port drive:
  - mem_addr follows the granted address.
  - mem_we = cpu_ack & cpu_we; mem_data = cpu_wdata.
  - With no grant, mem_addr holds its last value and mem_we = 0. A read is still issued, which is harmless.
- resp_tag register (states NONE, VID, CPU), updated every cycle:
  - VID if vid_ack.
  - CPU if cpu_ack & ~cpu_we.
  - NONE otherwise.
- Read latency: exactly 1 cycle from ack.
  - vid_rvalid = (resp_tag == VID); cpu_rvalid = (resp_tag == CPU).
  - vid_rdata and cpu_rdata are both driven from mem_q. They are meaningful only while the corresponding rvalid is high.
- Write completion: a CPU write completes in its ack cycle; no rvalid follows.
- Read-after-write to the same address on a later cycle returns the new data. Write-first is provided by the RAM.
- Back-to-back: one grant per cycle, full throughput. Pipelined reads produce consecutive rvalids in ack order.
- Starvation counter wait_cnt:
  - Increments when cpu_req & ~cpu_ack, saturating at MAX_WAIT.
  - Clears on cpu_ack, or when cpu_req is low.
  - Bound: with VID requesting every cycle, the CPU is granted no later than MAX_WAIT+1 cycles after cpu_req rises.
- Simultaneous requests with wait_cnt < MAX_WAIT: VID wins; the CPU keeps its request held.
- Requester rule: a requester must not change its address/data/we while req is high and ack is low. The arbiter does not check this.
- Reset mid-operation: an outstanding read response is dropped, so no rvalid follows reset deassertion, and wait_cnt restarts at 0.

Decomposition:
- Shared package:
  - resp_tag encoding: NONE = 2'd0, VID = 2'd1, CPU = 2'd2.
  - Default DATA_WIDTH/ADDR_WIDTH constants, shared with the RAM and CPU.
- Optional sub-module: starve_counter (saturating counter with inc/clr/at_max). All other logic stays inline.

Test Plan:
- Single VID read: preload RAM[0x0010]=0xBEEF; vid_req=1, addr=0x0010 for one cycle -> vid_ack in the same cycle; next cycle vid_rvalid=1, vid_rdata=0xBEEF; cpu_rvalid stays 0.
- CPU write then read: write 0x1234 to 0x00C8 (cpu_ack same cycle, mem_we=1, no rvalid); read 0x00C8 the following cycle -> cpu_rvalid one cycle after ack, cpu_rdata=0x1234.
- Contention/starvation: vid_req held high continuously, cpu_req raised at cycle t, MAX_WAIT=4 -> VID acked in cycles t..t+3; cpu_ack at t+4; vid_ack=0 at t+4; VID resumes at t+5; wait_cnt=0 after t+4.
- Pipelined reads: VID reads 0x0100, 0x0101, 0x0102 on consecutive cycles (RAM holds 0xA0, 0xA1, 0xA2) -> vid_rvalid high for 3 consecutive cycles, data 0xA0, 0xA1, 0xA2 in order.
- Alternating tags: VID read 0x0001 (=0x0011) in cycle n, CPU read 0x0002 (=0x0022) in cycle n+1 -> vid_rvalid only at n+1 with data 0x0011; cpu_rvalid only at n+2 with data 0x0022.
- Reset mid-read: assert reset asynchronously between ack and the response edge -> all outputs 0 immediately; no rvalid after reset deasserts; mem_we=0 throughout reset.
